// File: rtl/averager_ctrl_pkg.sv
// Shared definitions for the averager run controller: state encoding and width defaults.
package averager_ctrl_pkg;

  localparam int FAST_COUNT_WIDTH_DEF = 5;
  localparam int SLOW_COUNT_WIDTH_DEF = 10;
  localparam int TIMEOUT_WIDTH_DEF    = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ARM  = ST_ARM,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } run_state_t;

endpackage

// File: rtl/arc_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal flag that compares the
// current (pre-increment) count against a runtime limit.
module arc_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  // Flag reflects the count before this cycle's increment.
  assign at_limit = (count_reg == limit);

endmodule

// File: rtl/averager_run_controller.sv
// Sequences one averaging run: latch config on start, arm on trigger edge, gate clken for
// N sweeps, then hold data_valid until the readout acknowledges.
module averager_run_controller
  import averager_ctrl_pkg::*;
#(
  parameter int FAST_COUNT_WIDTH = FAST_COUNT_WIDTH_DEF,
  parameter int SLOW_COUNT_WIDTH = SLOW_COUNT_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH    = TIMEOUT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [SLOW_COUNT_WIDTH-1:0] n_target,
  input  logic [FAST_COUNT_WIDTH-1:0] period_max,
  input  logic                        avg_on_req,
  input  logic                        trigger,
  input  logic                        ready_i,
  input  logic [SLOW_COUNT_WIDTH-1:0] n_avg_i,
  output logic                        restart,
  output logic                        clken,
  output logic [FAST_COUNT_WIDTH-1:0] count_max,
  output logic                        avg_on,
  output logic                        data_valid,
  input  logic                        data_ack,
  output logic                        busy,
  output logic [SLOW_COUNT_WIDTH-1:0] n_avg_o,
  output logic                        timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LIMIT = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  run_state_t                  state_reg, state_next;
  logic                        restart_reg, restart_next;
  logic                        clken_reg, clken_next;
  logic [FAST_COUNT_WIDTH-1:0] count_max_reg, count_max_next;
  logic                        avg_on_reg, avg_on_next;
  logic                        data_valid_reg, data_valid_next;
  logic                        busy_reg, busy_next;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg_reg, n_avg_next;
  logic                        timeout_reg, timeout_next;
  logic [SLOW_COUNT_WIDTH-1:0] tgt_last_reg, tgt_last_next;
  logic                        trigger_q_reg;

  logic trig_rise;
  logic sweep_clr, sweep_en, sweep_term;
  logic tmo_clr, tmo_en, tmo_term;

  assign trig_rise = trigger & ~trigger_q_reg;
  assign sweep_en  = (state_reg == S_RUN) & ready_i & ~abort;
  assign tmo_en    = (state_reg == S_ARM);

  arc_sat_counter #(.WIDTH(SLOW_COUNT_WIDTH)) u_sweep_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (sweep_clr),
    .enable   (sweep_en),
    .limit    (tgt_last_reg),
    .at_limit (sweep_term)
  );

  arc_sat_counter #(.WIDTH(TIMEOUT_WIDTH)) u_tmo_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (tmo_clr),
    .enable   (tmo_en),
    .limit    (TMO_LIMIT),
    .at_limit (tmo_term)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      restart_reg    <= 1'b0;
      clken_reg      <= 1'b0;
      count_max_reg  <= '0;
      avg_on_reg     <= 1'b0;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      n_avg_reg      <= '0;
      timeout_reg    <= 1'b0;
      tgt_last_reg   <= '0;
      trigger_q_reg  <= 1'b0;
    end else begin
      restart_reg    <= restart_next;
      clken_reg      <= clken_next;
      count_max_reg  <= count_max_next;
      avg_on_reg     <= avg_on_next;
      data_valid_reg <= data_valid_next;
      busy_reg       <= busy_next;
      n_avg_reg      <= n_avg_next;
      timeout_reg    <= timeout_next;
      tgt_last_reg   <= tgt_last_next;
      trigger_q_reg  <= trigger;
    end
  end

  always_comb begin
    state_next      = state_reg;
    restart_next    = 1'b0;
    clken_next      = clken_reg;
    count_max_next  = count_max_reg;
    avg_on_next     = avg_on_reg;
    data_valid_next = data_valid_reg;
    n_avg_next      = n_avg_reg;
    timeout_next    = timeout_reg;
    tgt_last_next   = tgt_last_reg;
    sweep_clr       = 1'b0;
    tmo_clr         = 1'b0;

    if (abort) begin
      state_next      = S_IDLE;
      clken_next      = 1'b0;
      data_valid_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          clken_next      = 1'b0;
          data_valid_next = 1'b0;
          if (start) begin
            // Zero sweeps makes no sense for a run, so it is promoted to one.
            tgt_last_next  = (n_target == '0) ? '0 : n_target - SLOW_COUNT_WIDTH'(1);
            count_max_next = period_max;
            avg_on_next    = avg_on_req;
            timeout_next   = 1'b0;
            tmo_clr        = 1'b1;
            state_next     = S_ARM;
          end
        end
        S_ARM: begin
          clken_next = 1'b0;
          if (trig_rise) begin
            restart_next = 1'b1;
            clken_next   = 1'b1;
            sweep_clr    = 1'b1;
            state_next   = S_RUN;
          end else if (tmo_term) begin
            timeout_next = 1'b1;
            state_next   = S_IDLE;
          end
        end
        S_RUN: begin
          clken_next = 1'b1;
          if (ready_i && sweep_term) begin
            clken_next      = 1'b0;
            n_avg_next      = n_avg_i;
            data_valid_next = 1'b1;
            state_next      = S_DONE;
          end
        end
        S_DONE: begin
          clken_next      = 1'b0;
          data_valid_next = 1'b1;
          if (data_ack) begin
            data_valid_next = 1'b0;
            state_next      = S_IDLE;
          end
        end
        default: begin
          clken_next      = 1'b0;
          data_valid_next = 1'b0;
          state_next      = S_IDLE;
        end
      endcase
    end

    busy_next = (state_next != S_IDLE);
  end

  assign restart    = restart_reg;
  assign clken      = clken_reg;
  assign count_max  = count_max_reg;
  assign avg_on     = avg_on_reg;
  assign data_valid = data_valid_reg;
  assign busy       = busy_reg;
  assign n_avg_o    = n_avg_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_averager_run_controller.sv
// Randomized run-level bench for averager_run_controller; expectations come from the run
// rules (sweep count, latched config, handshake), tracked per run in plain variables.
module tb_averager_run_controller;

  localparam int FW = 5;
  localparam int SW = 10;
  localparam int TW = 4;
  localparam int ARM_LIMIT = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] n_target = '0;
  logic [FW-1:0] period_max = '0;
  logic          avg_on_req = 1'b0;
  logic          trigger = 1'b0;
  logic          ready_i = 1'b0;
  logic [SW-1:0] n_avg_i = '0;
  logic          data_ack = 1'b0;
  logic          restart, clken, avg_on, data_valid, busy, timeout;
  logic [FW-1:0] count_max;
  logic [SW-1:0] n_avg_o;

  averager_run_controller #(
    .FAST_COUNT_WIDTH (FW),
    .SLOW_COUNT_WIDTH (SW),
    .TIMEOUT_WIDTH    (TW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .n_target   (n_target),
    .period_max (period_max),
    .avg_on_req (avg_on_req),
    .trigger    (trigger),
    .ready_i    (ready_i),
    .n_avg_i    (n_avg_i),
    .restart    (restart),
    .clken      (clken),
    .count_max  (count_max),
    .avg_on     (avg_on),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .busy       (busy),
    .n_avg_o    (n_avg_o),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int restart_cnt = 0;
  int clken_cnt = 0;
  int run_id = 0;

  // Reference state: what the controller should be holding between/within runs.
  logic [FW-1:0] exp_cmax = '0;
  logic          exp_avg = 1'b0;
  logic [SW-1:0] exp_navg = '0;
  logic          exp_timeout = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    restart_cnt += int'(restart);
    clken_cnt   += int'(clken);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_restart"}, 32'(restart), 0);
    check({tag, "_clken"}, 32'(clken), 0);
    check({tag, "_count_max"}, 32'(count_max), 0);
    check({tag, "_avg_on"}, 32'(avg_on), 0);
    check({tag, "_data_valid"}, 32'(data_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_n_avg_o"}, 32'(n_avg_o), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic start_run(input logic [SW-1:0] n, input logic [FW-1:0] pm, input logic av);
    n_target = n; period_max = pm; avg_on_req = av; trigger = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cmax = pm; exp_avg = av; exp_timeout = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_count_max", 32'(count_max), 32'(exp_cmax));
    check("start_avg_on", 32'(avg_on), 32'(exp_avg));
    check("start_timeout", 32'(timeout), 0);
    check("start_clken", 32'(clken), 0);
    // Host config changes mid-run must not reach the latched outputs.
    n_target = SW'($urandom); period_max = FW'($urandom); avg_on_req = 1'($urandom);
  endtask

  task automatic arm_wait(input int d);
    for (int i = 0; i < d; i++) begin
      trigger = 1'b0;
      start = 1'($urandom);
      tick();
      start = 1'b0;
      check("arm_restart", 32'(restart), 0);
      check("arm_clken", 32'(clken), 0);
      check("arm_busy", 32'(busy), 1);
    end
  endtask

  task automatic run_sweeps(input int n_eff);
    int ticks;
    trigger = 1'b1;
    restart_cnt = 0;
    clken_cnt = 0;
    tick();
    ticks = 1;
    check("trig_restart", 32'(restart), 1);
    check("trig_clken", 32'(clken), 1);
    for (int i = 0; i < n_eff; i++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        trigger = 1'($urandom);
        start = 1'($urandom);
        data_ack = 1'($urandom);
        tick();
        ticks++;
        start = 1'b0;
        data_ack = 1'b0;
        check("run_clken", 32'(clken), 1);
        check("run_data_valid", 32'(data_valid), 0);
      end
      ready_i = 1'b1;
      n_avg_i = SW'($urandom);
      exp_navg = n_avg_i;
      tick();
      ticks++;
      ready_i = 1'b0;
      if (i < n_eff - 1) begin
        check("sweep_clken", 32'(clken), 1);
        check("sweep_data_valid", 32'(data_valid), 0);
      end else begin
        check("last_clken", 32'(clken), 0);
        check("last_data_valid", 32'(data_valid), 1);
        check("last_n_avg_o", 32'(n_avg_o), 32'(exp_navg));
      end
    end
    check("run_restart_pulses", 32'(restart_cnt), 1);
    check("run_clken_cycles", 32'(clken_cnt), 32'(ticks - 1));
  endtask

  task automatic finish_run(input int ack_delay);
    trigger = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      start = 1'($urandom);
      tick();
      start = 1'b0;
      check("done_data_valid", 32'(data_valid), 1);
      check("done_busy", 32'(busy), 1);
      check("done_clken", 32'(clken), 0);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check("ack_data_valid", 32'(data_valid), 0);
    check("ack_busy", 32'(busy), 0);
    check("ack_n_avg_o", 32'(n_avg_o), 32'(exp_navg));
    check("ack_count_max", 32'(count_max), 32'(exp_cmax));
    check("ack_avg_on", 32'(avg_on), 32'(exp_avg));
    check("ack_restart_pulses", 32'(restart_cnt), 1);
    tick();
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic do_run(input logic [SW-1:0] n, input logic [FW-1:0] pm, input logic av,
                        input int d, input int ack_delay);
    int n_eff;
    n_eff = (n == '0) ? 1 : int'(n);
    start_run(n, pm, av);
    arm_wait(d);
    run_sweeps(n_eff);
    finish_run(ack_delay);
    run_id++;
    $display("[TB] run %0d: n_target=%0d period_max=%0d avg_on=%0d trig_delay=%0d n_avg_o=%0h",
             run_id, n, pm, av, d, exp_navg);
  endtask

  initial begin
    resetn = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Basic run and n_target=0 treated as one sweep.
    do_run(10'd4, 5'd15, 1'b1, 10, 3);
    do_run(10'd0, 5'd7, 1'b0, 2, 0);

    // Trigger wait expiry: 15 ARM cycles then back to IDLE with sticky timeout.
    start_run(10'd3, 5'd9, 1'b1);
    restart_cnt = 0;
    for (int i = 1; i < ARM_LIMIT; i++) begin
      tick();
      check("tmo_pending", 32'(timeout), 0);
      check("tmo_busy", 32'(busy), 1);
    end
    tick();
    check("tmo_set", 32'(timeout), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_clken", 32'(clken), 0);
    check("tmo_no_restart", 32'(restart_cnt), 0);
    tick();
    check("tmo_sticky", 32'(timeout), 1);
    $display("[TB] timeout run: timeout=%0d busy=%0d", timeout, busy);

    // Trigger on the final ARM cycle wins over the timeout.
    do_run(10'd2, 5'd3, 1'b0, ARM_LIMIT - 1, 1);

    // Abort after 2 of 8 sweeps.
    start_run(10'd8, 5'd20, 1'b1);
    arm_wait(3);
    trigger = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_clken", 32'(clken), 0);
    check("abort_data_valid", 32'(data_valid), 0);
    check("abort_n_avg_o", 32'(n_avg_o), 32'(exp_navg));
    for (int i = 0; i < 8; i++) begin
      ready_i = 1'($urandom);
      trigger = 1'($urandom);
      data_ack = 1'($urandom);
      tick();
      check("post_abort_dv", 32'(data_valid), 0);
      check("post_abort_clken", 32'(clken), 0);
    end
    ready_i = 1'b0; trigger = 1'b0; data_ack = 1'b0;

    // Abort wins over a simultaneous start in IDLE.
    n_target = 10'd5; period_max = ~exp_cmax; avg_on_req = ~exp_avg;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_cmax", 32'(count_max), 32'(exp_cmax));
    check("abort_start_avg", 32'(avg_on), 32'(exp_avg));
    tick();
    check("abort_start_idle", 32'(busy), 0);
    $display("[TB] abort run: busy=%0d clken=%0d data_valid=%0d", busy, clken, data_valid);

    // Asynchronous reset in the middle of RUN.
    start_run(10'd5, 5'd11, 1'b1);
    arm_wait(2);
    trigger = 1'b1;
    tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    trigger = 1'b0;
    resetn = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    tick();
    resetn = 1'b1;
    tick();
    check_all_zero("after_midrun_reset");
    exp_navg = '0;
    $display("[TB] reset-in-run: busy=%0d clken=%0d", busy, clken);
    do_run(10'd3, 5'd6, 1'b1, 4, 2);

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      do_run(SW'($urandom_range(0, 6)), FW'($urandom), 1'($urandom),
             $urandom_range(0, ARM_LIMIT - 1), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
